// File: rtl/prio_pkg.sv
// Shared definitions for the priority encoder family.
//   MODE_FIXED / MODE_RR : values of the mode input
//   clog2                : ceiling log2, used to size grant indices
package prio_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/prio_search.sv
// Circular first-set-bit search over an N-bit vector.
//   vec_i    : candidate vector
//   start_i  : first index examined (0..N-1)
//   found_o  : some bit of vec_i is set
//   idx_o    : winning index (0 when nothing found)
//   onehot_o : 1 << idx_o when found, else 0
// MSB_FIRST=0 walks start, start+1, ... wrapping N-1 -> 0.
// MSB_FIRST=1 walks start, start-1, ... wrapping 0 -> N-1.
module prio_search
  import prio_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned W        = clog2(N)
) (
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] onehot_o
);

  always_comb begin
    int pos;
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    // Walk from the far end back toward start so the nearest hit is written last.
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (MSB_FIRST) begin
        pos = int'(start_i) + int'(N) - k;
      end else begin
        pos = int'(start_i) + k;
      end
      // Index stays mod N, never mod 2^W; start_i < N so one subtract suffices.
      if (pos >= int'(N)) begin
        pos = pos - int'(N);
      end
      if (vec_i[pos]) begin
        found_o = 1'b1;
        idx_o   = W'(pos);
      end
    end
    onehot_o = found_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered N-to-log2(N) priority encoder with fixed or round-robin priority
// and a valid/ready output handshake.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : request vector, sampled only on a capture edge
//   mode      : 0 fixed (highest index wins), 1 round-robin
//   out_ready : consumer accepts the current grant
//   out_valid : grant registers hold a result
//   idx/grant : encoded and one-hot grant
//   out_multi : more than one request was set at capture
module rr_priority_encoder
  import prio_pkg::*;
#(
  parameter int unsigned N  = 8,
  localparam int unsigned W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant,
  output logic         out_multi
);

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] grant_q, grant_d;
  logic         multi_q, multi_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         capture;
  logic [W-1:0] rr_start;

  logic         fx_found, rr_found, sel_found;
  logic [W-1:0] fx_idx, rr_idx, sel_idx;
  logic [N-1:0] fx_onehot, rr_onehot, sel_onehot;

  assign capture = !valid_q || out_ready;

  // Round-robin search begins just past the last winner; reset ptr is N-1 so it starts at 0.
  assign rr_start = (ptr_q == W'(N - 1)) ? '0 : ptr_q + W'(1);

  prio_search #(
    .N        (N),
    .MSB_FIRST(1'b1)
  ) u_fixed_search (
    .vec_i   (req),
    .start_i (W'(N - 1)),
    .found_o (fx_found),
    .idx_o   (fx_idx),
    .onehot_o(fx_onehot)
  );

  prio_search #(
    .N        (N),
    .MSB_FIRST(1'b0)
  ) u_rr_search (
    .vec_i   (req),
    .start_i (rr_start),
    .found_o (rr_found),
    .idx_o   (rr_idx),
    .onehot_o(rr_onehot)
  );

  assign sel_found  = (mode == MODE_RR) ? rr_found  : fx_found;
  assign sel_idx    = (mode == MODE_RR) ? rr_idx    : fx_idx;
  assign sel_onehot = (mode == MODE_RR) ? rr_onehot : fx_onehot;

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    multi_d = multi_q;
    ptr_d   = ptr_q;
    if (capture) begin
      if (sel_found) begin
        valid_d = 1'b1;
        idx_d   = sel_idx;
        grant_d = sel_onehot;
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi_d = |(req & (req - N'(1)));
        ptr_d   = sel_idx;
      end else begin
        valid_d = 1'b0;
        idx_d   = '0;
        grant_d = '0;
        multi_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      grant_q <= '0;
      multi_q <= 1'b0;
      ptr_q   <= W'(N - 1);
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      multi_q <= multi_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign idx       = idx_q;
  assign grant     = grant_q;
  assign out_multi = multi_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
module tb_rr_priority_encoder;

  typedef struct {
    logic       valid;
    logic [2:0] idx;
    logic [7:0] grant;
    logic       multi;
    int         ptr;
  } st_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req8;
  logic [4:0] req5;
  logic       mode;
  logic       out_ready;

  logic       v8, mu8, v5, mu5;
  logic [2:0] idx8, idx5;
  logic [7:0] g8;
  logic [4:0] g5;

  int nvec  = 0;
  int nfail = 0;

  st_t m8, m5, e8, e5;
  st_t q8[$];
  st_t q5[$];

  always #5 clk = ~clk;

  rr_priority_encoder #(.N(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .req      (req8),
    .mode     (mode),
    .out_ready(out_ready),
    .out_valid(v8),
    .idx      (idx8),
    .grant    (g8),
    .out_multi(mu8)
  );

  rr_priority_encoder #(.N(5)) u_dut5 (
    .clk      (clk),
    .rst      (rst),
    .req      (req5),
    .mode     (mode),
    .out_ready(out_ready),
    .out_valid(v5),
    .idx      (idx5),
    .grant    (g5),
    .out_multi(mu5)
  );

  function automatic st_t reset_state(input int n);
    st_t s;
    s.valid = 1'b0;
    s.idx   = '0;
    s.grant = '0;
    s.multi = 1'b0;
    s.ptr   = n - 1;
    return s;
  endfunction

  // Reference behaviour for one clock edge of an n-line encoder.
  function automatic st_t nxt(input int n, input st_t s, input logic [7:0] r,
                              input logic m, input logic rdy);
    st_t        o;
    logic [7:0] v;
    int         w;
    o = s;
    if (s.valid && !rdy) return s;
    v = r & 8'((1 << n) - 1);
    if (v == 8'h00) begin
      o.valid = 1'b0;
      o.idx   = '0;
      o.grant = '0;
      o.multi = 1'b0;
      return o;
    end
    w = -1;
    if (!m) begin
      for (int i = 0; i < n; i++) if (v[i]) w = i;
    end else begin
      for (int k = n; k >= 1; k--) if (v[(s.ptr + k) % n]) w = (s.ptr + k) % n;
    end
    o.valid = 1'b1;
    o.idx   = 3'(w);
    o.grant = 8'(1) << w;
    o.multi = ($countones(v) > 1);
    o.ptr   = w;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input st_t x8, input st_t x5);
    chk({tag, "/n8"}, {v8, idx8, g8, mu8}, {x8.valid, x8.idx, x8.grant, x8.multi});
    chk({tag, "/n5"}, {3'b000, v5, idx5, g5, mu5},
        {3'b000, x5.valid, x5.idx, x5.grant[4:0], x5.multi});
  endtask

  // Drive one cycle; expected results are queued now and popped after the edge.
  task automatic cycle(input string tag, input logic [7:0] r, input logic m, input logic rdy);
    req8      = r;
    req5      = r[4:0];
    mode      = m;
    out_ready = rdy;
    m8 = nxt(8, m8, r, m, rdy);
    m5 = nxt(5, m5, r, m, rdy);
    q8.push_back(m8);
    q5.push_back(m5);
    @(posedge clk);
    #1;
    e8 = q8.pop_front();
    e5 = q5.pop_front();
    check_outputs(tag, e8, e5);
  endtask

  initial begin
    rst       = 1'b1;
    req8      = 8'h00;
    req5      = 5'h00;
    mode      = 1'b0;
    out_ready = 1'b1;
    m8 = reset_state(8);
    m5 = reset_state(5);
    #2;
    check_outputs("reset", m8, m5);
    #6;
    rst = 1'b0;

    // Fixed priority, walking one.
    for (int i = 0; i < 8; i++) cycle("walk", 8'(1) << i, 1'b0, 1'b1);

    // Fixed priority, multiple requests then none.
    cycle("fixed_a5", 8'hA5, 1'b0, 1'b1);
    cycle("fixed_00", 8'h00, 1'b0, 1'b1);

    // Round-robin rotation over all requests.
    for (int i = 0; i < 9; i++) cycle("rr_ff", 8'hFF, 1'b1, 1'b1);

    // Stall: grant idx 0 then hold while req and mode wiggle.
    cycle("rr_80", 8'h80, 1'b1, 1'b1);
    cycle("rr_11", 8'h11, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle("stall", 8'(i * 37 + 3), 1'(i), 1'b0);
    cycle("unstall1", 8'h11, 1'b1, 1'b1);
    cycle("unstall2", 8'h11, 1'b1, 1'b1);

    // Wrap and self re-grant.
    cycle("wrap_80", 8'h80, 1'b1, 1'b1);
    cycle("wrap_81", 8'h81, 1'b1, 1'b1);
    cycle("wrap_80b", 8'h80, 1'b1, 1'b1);
    cycle("self_80", 8'h80, 1'b1, 1'b1);

    // Fixed-mode capture moves the round-robin pointer.
    cycle("fix_08", 8'h08, 1'b0, 1'b1);
    cycle("rr_after_fix", 8'hFF, 1'b1, 1'b1);

    // Asynchronous reset mid-stream.
    cycle("pre_rst1", 8'hFF, 1'b1, 1'b1);
    cycle("pre_rst2", 8'hFF, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    m8 = reset_state(8);
    m5 = reset_state(5);
    check_outputs("async_rst", m8, m5);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle("post_rst", 8'hFF, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
